// File: rtl/fifo_ctrl.sv
// FIFO controller in front of an external dual-port RAM with a registered read port.
// Define FIFO_CTRL_LEVEL_EN to expose the occupancy count on the `level` output.
module fifo_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   ram_write,
  output logic [ADDR_LENGTH-1:0] ram_w_addr,
  output logic [ADDR_LENGTH-1:0] ram_r_addr,
  output logic [WORD_LENGTH-1:0] ram_data_in,
  input  logic [WORD_LENGTH-1:0] ram_data_out
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_LENGTH:0]   level
`endif
);

  localparam logic [ADDR_LENGTH:0]   DEPTH_C  = ADDR_LENGTH'(1) << ADDR_LENGTH;
  localparam logic [ADDR_LENGTH-1:0] ADDR_ONE = ADDR_LENGTH'(1);

  logic [ADDR_LENGTH:0]   count_q, count_d;
  logic [ADDR_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LENGTH-1:0] head_ptr_q, head_ptr_d;
  logic                   out_valid_q, out_valid_d;

  logic                   push, pop, fetch;
  logic [ADDR_LENGTH:0]   unfetched;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = out_valid_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid_q & out_ready;

  // Words already in RAM but not yet loaded into the output register.
  assign unfetched = count_q - {{ADDR_LENGTH{1'b0}}, out_valid_q};
  assign fetch     = (unfetched != '0) && (!out_valid_q || out_ready);

  assign ram_write   = push;
  assign ram_w_addr  = wr_ptr_q;
  assign ram_data_in = in_data;
  assign out_data    = ram_data_out;

`ifdef FIFO_CTRL_LEVEL_EN
  assign level = count_q;
`endif

  always_comb begin
    ram_r_addr = head_ptr_q;
    if (fetch && out_valid_q) begin
      ram_r_addr = head_ptr_q + ADDR_ONE;
    end else if (!fetch && !out_valid_q) begin
      // Empty and idle: head_ptr equals wr_ptr, so park the read one slot back
      // to keep the read port off the slot that may be written this cycle.
      ram_r_addr = head_ptr_q - ADDR_ONE;
    end
  end

  always_comb begin
    count_d     = count_q + {{ADDR_LENGTH{1'b0}}, push} - {{ADDR_LENGTH{1'b0}}, pop};
    wr_ptr_d    = push ? (wr_ptr_q + ADDR_ONE) : wr_ptr_q;
    out_valid_d = fetch | (out_valid_q & ~out_ready);
    head_ptr_d  = head_ptr_q;
    if (fetch) begin
      head_ptr_d = ram_r_addr;
    end else if (pop) begin
      // Last word leaves: the next word to arrive lands at head_ptr+1.
      head_ptr_d = head_ptr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      head_ptr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      head_ptr_q  <= head_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
